// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way write-through cache: geometry, address
// slicing, FSM encoding and the per-way line record.
package cache_pkg;

  localparam int SETS    = 64;
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = 11;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  // Byte address layout: [1:0] byte offset, then index, then tag; bits above
  // the tag are not decoded, so such addresses alias onto the same lines.
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = IDX_LSB + INDEX_W - 1;
  localparam int TAG_LSB = IDX_MSB + 1;
  localparam int TAG_MSB = TAG_LSB + TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [DATA_W-1:0]  word_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    word_t data;
  } line_t;

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: SETS lines of {valid, tag, data}.
// Asynchronous read by index, synchronous write, synchronous invalidate-all
// on rst.
module cache_way_array
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t rd_idx,
  output line_t  rd_line,
  input  logic   we,
  input  index_t wr_idx,
  input  tag_t   wr_tag,
  input  word_t  wr_data
);

  logic [SETS-1:0] valid;
  tag_t            tag_mem  [SETS];
  word_t           data_mem [SETS];

  // Valid bits: cleared together on reset, set by any line write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage.
  // NOTE: the tag/data arrays have no reset; a line is ignored until its valid
  // bit is set, so clearing the storage itself would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Asynchronous lookup so hits can be answered in the request cycle.
  always_comb begin
    rd_line.valid = valid[rd_idx];
    rd_line.tag   = tag_mem[rd_idx];
    rd_line.data  = data_mem[rd_idx];
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate word cache between
// the MEM stage and the SRAM controller. Read hits complete in the request
// cycle; read misses and all writes go through the SRAM handshake while the
// pipeline is frozen via ready = 0.
// Optional build macro CACHE_STATS_EN adds read hit/miss counters.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_W_EN,
  output logic        sram_R_EN,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t          state;
  logic [SETS-1:0] lru;       // per set: the way to replace next

  index_t idx;
  tag_t   req_tag;
  line_t  line0, line1;
  logic   hit0, hit1, hit, hit_way;
  word_t  hit_data;
  logic   wr_req, rd_req;
  logic   fill, wr_done;
  logic   we0, we1;
  word_t  line_wdata;

  assign idx     = address[IDX_MSB:IDX_LSB];
  assign req_tag = address[TAG_MSB:TAG_LSB];

  // Writes take priority over reads when both are requested.
  assign wr_req = MEM_W_EN;
  assign rd_req = MEM_R_EN & ~MEM_W_EN;

  // Requests are forwarded unmodified; the enables qualify them.
  assign sram_address = address;
  assign sram_wdata   = wdata;

  cache_way_array u_way0 (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_line (line0),
    .we      (we0),
    .wr_idx  (idx),
    .wr_tag  (req_tag),
    .wr_data (line_wdata)
  );

  cache_way_array u_way1 (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_line (line1),
    .we      (we1),
    .wr_idx  (idx),
    .wr_tag  (req_tag),
    .wr_data (line_wdata)
  );

  assign hit0     = line0.valid && (line0.tag == req_tag);
  assign hit1     = line1.valid && (line1.tag == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_data = hit1 ? line1.data : line0.data;

  // A fill lands in the LRU way; a write completion only refreshes a hit way.
  assign fill       = (state == READ_MISS) && sram_ready;
  assign wr_done    = (state == WRITE) && sram_ready;
  assign we0        = (fill && !lru[idx]) || (wr_done && hit0);
  assign we1        = (fill &&  lru[idx]) || (wr_done && hit1);
  assign line_wdata = fill ? sram_rdata : wdata;

  // Control FSM with registered SRAM enables and LRU bookkeeping.
  // NOTE: all sequential state uses <= so every flop sees pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lru       <= '0;
      sram_R_EN <= 1'b0;
      sram_W_EN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            state     <= WRITE;
            sram_W_EN <= 1'b1;
          end else if (rd_req) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
            end else begin
              state     <= READ_MISS;
              sram_R_EN <= 1'b1;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            lru[idx]  <= ~lru[idx];
            state     <= IDLE;
            sram_R_EN <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
            end
            state     <= IDLE;
            sram_W_EN <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sram_R_EN <= 1'b0;
          sram_W_EN <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline handshake and load data; zero-latency on hits and fills.
  // NOTE: both outputs get a default before the case so no path can leave
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    ready = 1'b1;
    rdata = '0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          ready = 1'b0;
        end else if (rd_req) begin
          if (hit) begin
            rdata = hit_data;
          end else begin
            ready = 1'b0;
          end
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) begin
          rdata = sram_rdata;
        end
      end
      WRITE: begin
        ready = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  // Read hit/miss event counters; a miss is counted on entry to READ_MISS.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && rd_req) begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

  // Fills only happen on a miss, so one set can never hold a tag twice.
  assert property (@(posedge clk) disable iff (rst) !(hit0 && hit1))
    else $error("both cache ways hit the same address");

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller. The driver pushes the hand-derived
// expected outcome of each request; a monitor pops it when the DUT raises
// ready for that request and compares stall length, SRAM enables and rdata.
// A behavioural SRAM controller answers each request after LAT cycles.
module tb_cache_controller;

  localparam int LAT     = 5;
  localparam int TIMEOUT = 40;

  typedef enum int { K_HIT, K_MISS, K_WRITE } kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_W_EN, sram_R_EN;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready, model_ready, stray_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  assign sram_ready = model_ready | stray_ready;

  exp_t        sb[$];
  int          pass_cnt;
  int          total_cnt;
  logic [31:0] mem [logic [31:0]];

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_W_EN    (sram_W_EN),
    .sram_R_EN    (sram_R_EN),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Backing store: unwritten words return a pattern derived from the address.
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hA5A5};
  endfunction

  // SRAM controller model: pulses ready after LAT cycles of a held enable.
  initial begin
    int cnt;
    cnt         = 0;
    model_ready = 1'b0;
    sram_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        cnt         = 0;
        model_ready = 1'b0;
      end else if (model_ready) begin
        model_ready = 1'b0;
      end else if (sram_R_EN || sram_W_EN) begin
        cnt++;
        if (cnt == LAT) begin
          cnt         = 0;
          model_ready = 1'b1;
          if (sram_W_EN) mem[sram_address] = sram_wdata;
          else           sram_rdata = sram_word(sram_address);
        end
      end
    end
  end

  // Monitor: compare each completed request against the scoreboard head.
  initial begin
    int   stall;
    logic seen_r, seen_w;
    exp_t e;
    stall  = 0;
    seen_r = 1'b0;
    seen_w = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall  = 0;
        seen_r = 1'b0;
        seen_w = 1'b0;
      end else if (MEM_R_EN || MEM_W_EN) begin
        seen_r = seen_r | sram_R_EN;
        seen_w = seen_w | sram_W_EN;
        if (!ready) begin
          stall++;
        end else begin
          if (sb.size() == 0) begin
            check("sb_unexpected_response", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check({e.name, "_stall"}, 32'(stall), (e.kind == K_HIT) ? 32'd0 : 32'(LAT));
            check({e.name, "_sram_r_en"}, 32'(seen_r), 32'(e.kind == K_MISS));
            check({e.name, "_sram_w_en"}, 32'(seen_w), 32'(e.kind == K_WRITE));
            if (e.kind != K_WRITE) check({e.name, "_rdata"}, rdata, e.data);
          end
          stall  = 0;
          seen_r = 1'b0;
          seen_w = 1'b0;
        end
      end
    end
  end

  // Issue one request (called at posedge+1) and hold it until ready.
  task automatic issue(input string name, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input kind_t k, input logic [31:0] exp_data);
    exp_t e;
    int   n;
    e.name = name;
    e.kind = k;
    e.data = exp_data;
    sb.push_back(e);
    MEM_R_EN = r;
    MEM_W_EN = w;
    address  = a;
    wdata    = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < TIMEOUT);
    if (!ready) check({name, "_timeout"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    pass_cnt    = 0;
    total_cnt   = 0;
    rst         = 1'b1;
    MEM_R_EN    = 1'b0;
    MEM_W_EN    = 1'b0;
    address     = '0;
    wdata       = '0;
    stray_ready = 1'b0;
    mem[32'h0000_0100] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready",     32'(ready),     32'd1);
    check("reset_sram_r_en", 32'(sram_R_EN), 32'd0);
    check("reset_sram_w_en", 32'(sram_W_EN), 32'd0);
    check("reset_rdata",     rdata,          32'd0);
`ifdef CACHE_STATS_EN
    check("reset_hit_count",  hit_count,  32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1;

    // All of 0x100/0x200/0x300/0x400 map to set 0 with tags 1..4.
    issue("cold_rd_100",  1, 0, 32'h0000_0100, '0, K_MISS,  32'hDEAD_BEEF);
    issue("hit_rd_100",   1, 0, 32'h0000_0100, '0, K_HIT,   32'hDEAD_BEEF);
    issue("miss_rd_200",  1, 0, 32'h0000_0200, '0, K_MISS,  32'h0200_A5A5);
    issue("evict_rd_300", 1, 0, 32'h0000_0300, '0, K_MISS,  32'h0300_A5A5);
    issue("hit_rd_200",   1, 0, 32'h0000_0200, '0, K_HIT,   32'h0200_A5A5);
    issue("evicted_100",  1, 0, 32'h0000_0100, '0, K_MISS,  32'hDEAD_BEEF);
    issue("wr_hit_100",   0, 1, 32'h0000_0100, 32'h1234_5678, K_WRITE, '0);
    issue("rd_after_wr",  1, 0, 32'h0000_0100, '0, K_HIT,   32'h1234_5678);
    issue("wr_miss_400",  0, 1, 32'h0000_0400, 32'hCAFE_F00D, K_WRITE, '0);
    issue("no_alloc_400", 1, 0, 32'h0000_0400, '0, K_MISS,  32'hCAFE_F00D);
    issue("rw_both_100",  1, 1, 32'h0000_0100, 32'h0BAD_F00D, K_WRITE, '0);
    issue("rd_after_rw",  1, 0, 32'h0000_0100, '0, K_HIT,   32'h0BAD_F00D);
    issue("alias_hi_bits",1, 0, 32'h8000_0100, '0, K_HIT,   32'h0BAD_F00D);

    // A completion pulse while idle must be ignored.
    stray_ready = 1'b1;
    @(negedge clk);
    check("stray_ready_ready",     32'(ready),     32'd1);
    check("stray_ready_sram_r_en", 32'(sram_R_EN), 32'd0);
    @(posedge clk);
    #1 stray_ready = 1'b0;

    issue("post_stray_100", 1, 0, 32'h0000_0100, '0, K_HIT,  32'h0BAD_F00D);
    issue("miss_rd_104",    1, 0, 32'h0000_0104, '0, K_MISS, 32'h0104_A5A5);
    issue("hit_rd_104",     1, 0, 32'h0000_0104, '0, K_HIT,  32'h0104_A5A5);
`ifdef CACHE_STATS_EN
    check("stats_hit_count",  hit_count,  32'd7);
    check("stats_miss_count", miss_count, 32'd6);
`endif

    // Reset in the middle of a read miss.
    MEM_R_EN = 1'b1;
    address  = 32'h0000_0800;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_read_miss", 32'(sram_R_EN), 32'd1);
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_sram_r_en", 32'(sram_R_EN), 32'd0);
    check("abort_sram_w_en", 32'(sram_W_EN), 32'd0);
    check("abort_ready",     32'(ready),     32'd1);
`ifdef CACHE_STATS_EN
    check("abort_hit_count",  hit_count,  32'd0);
    check("abort_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    issue("invalidated_100", 1, 0, 32'h0000_0100, '0, K_MISS, 32'h0BAD_F00D);
    issue("invalidated_104", 1, 0, 32'h0000_0104, '0, K_MISS, 32'h0104_A5A5);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate word cache between the MEM stage and the SRAM controller.
- Serves read hits in zero wait cycles.
- Read misses and all writes are forwarded to the SRAM controller over its W_EN/R_EN/address/data/ready handshake.
- Drives a ready/stall signal back to the pipeline.

Parameters:
- SETS, 64, number of sets (index width = log2(SETS) = 6).
- TAG_W, 11, tag bits, address[18:8].
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- MEM_R_EN  in  1  pipeline read request
- MEM_W_EN  in  1  pipeline write request
- address  in  32  byte address; [1:0] ignored, [7:2] index, [18:8] tag, [31:19] ignored
- wdata  in  32  store data
- rdata  out  32  load data
- ready  out  1  1 = MEM stage may advance; 0 = freeze pipeline
- sram_W_EN  out  1  write request to SRAM controller
- sram_R_EN  out  1  read request to SRAM controller
- sram_address  out  32  forwarded address, unmodified
- sram_wdata  out  32  forwarded store data
- sram_rdata  in  32  SRAM controller read data, valid when sram_ready = 1
- sram_ready  in  1  one-cycle completion pulse from SRAM controller

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset state:
  - state = IDLE; all valid bits = 0; all LRU bits = 0.
  - sram_W_EN = sram_R_EN = 0; rdata = 0; ready = 1 when no request is present.
- Hit detection (combinational):
  - hit_w = valid[w][idx] & (tag[w][idx] == address[18:8]).
  - Both ways hitting is illegal by construction. Cover-assert it never occurs.
- Request priority: MEM_W_EN over MEM_R_EN when both are 1, same rule as the SRAM controller.
- States: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: ready = 1, next state IDLE.
  - Read hit: rdata = hit way's data, ready = 1 in the same cycle (0 latency); LRU[idx] = ~hit_way.
  - Read miss: ready = 0, next state READ_MISS.
  - Write: ready = 0, next state WRITE.
- READ_MISS:
  - sram_R_EN = 1, decoded from state (registered).
  - ready = 0 until sram_ready.
  - On the sram_ready cycle:
    - Write way LRU[idx] with {valid=1, tag, sram_rdata}.
    - Flip LRU[idx].
    - rdata = sram_rdata, ready = 1.
    - Next state IDLE.
- WRITE:
  - sram_W_EN = 1, sram_wdata = wdata.
  - ready = 0 until sram_ready.
  - On the sram_ready cycle:
    - If hit: update that way's data and set LRU[idx] = ~hit_way.
    - If miss: no allocation.
    - ready = 1; next state IDLE.
- Both sram enables are 0 in IDLE, so the SRAM controller (back in its IDLE after READY_STATE) never sees a stale request.
- Pipeline inputs are held stable while ready = 0; the block does not latch them.
- Completion cycle for a read miss: the returned word is visible on rdata that cycle and the array is updated at the same edge.
- rst asserted mid-transaction:
  - Returns to IDLE at the next edge and invalidates all lines.
  - The SRAM controller shares rst, so no transaction is left dangling.
- A sram_ready received in IDLE is ignored.
- Address wrap: only [18:2] is significant. Addresses differing only in [31:19] alias.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0]. Both reset to 0.
  - hit_count increments once per read hit.
  - miss_count increments once per read miss, on entry to READ_MISS.
  - Writes are not counted. Counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - SETS, INDEX_W, TAG_W, DATA_W.
  - Address slice positions.
  - State encoding IDLE = 2'd0, READ_MISS = 2'd1, WRITE = 2'd2.
- Sub-module cache_way_array, instantiated twice:
  - SETS entries of {valid, tag, data}.
  - Synchronous write, asynchronous read.
  - Synchronous invalidate-all on rst.
- LRU bits, FSM and muxing stay in cache_controller.

Test Plan:
- Cold read 0x0000_0100 with SRAM model returning 0xDEAD_BEEF after 5 cycles:
  - ready = 0 for 5 cycles, then rdata = 0xDEAD_BEEF with ready = 1.
  - Repeat read: ready = 1 and the same data in the same cycle, no sram_R_EN.
- Reads of 0x100, 0x200, 0x300 (same index 0, different tags):
  - Third read evicts the 0x100 line.
  - Re-reading 0x200 hits; 0x100 misses.
- Write 0x1234_5678 to cached 0x100:
  - sram_W_EN held until sram_ready.
  - Subsequent read hits with 0x1234_5678.
- Write to uncached 0x400, then read 0x400: the read misses (no write allocate).
- MEM_R_EN and MEM_W_EN both 1: WRITE path taken, sram_R_EN stays 0.
- rst pulsed during READ_MISS:
  - IDLE next cycle, enables 0.
  - Previous hit address now misses.
  - With CACHE_STATS_EN defined, counters read 0.
